dpll_core: RTL and testbench
============================

// Module: dpll_core
// PURPOSE
//   Digital PLL core built from three stages: phase-frequency detector (PFD), integrating loop filter, and a
//   digitally controlled oscillator (DCO). The PFD compares reference d1 against feedback d2 and produces up/dn.
//   The filter integrates up/dn into an 8-bit control word speed_var.
//   The DCO is a phase accumulator whose MSB is the synthesized clock signal_out.
// PARAMETERS
//   SPEED_W     8      control-word width (speed_var)
//   SPEED_RST   128    speed_var value after reset (mid-range)
//   KI          1      filter step per cycle while up or dn is active
//   ACC_W       16     DCO phase-accumulator width
//   BASE_INC    256    DCO free-running increment added to speed_var
//   LOCK_CYCLES 16     quiet cycles before lock is asserted (optional feature only)
// PORTS
//   clk        in   1        single clock; all state updates on rising edge
//   rst        in   1        synchronous, active-high reset
//   d1         in   1        reference input (synchronous to clk, held >= 1 cycle)
//   d2         in   1        feedback input (synchronous to clk, held >= 1 cycle)
//   mod        in   1        DCO range select: 0 = normal, 1 = half-rate
//   up         out  1        PFD: reference leads
//   dn         out  1        PFD: feedback leads
//   speed_var  out  SPEED_W  filter output / DCO control word
//   signal_out out  1        DCO output clock
//   lock       out  1        present only when PLL_LOCK_DETECT_EN is defined
// BEHAVIOUR
//   Interface: one clock (clk); reset rst is synchronous, active-high.
//   Reset: up=0, dn=0, speed_var=SPEED_RST, accumulator=0, signal_out=0, lock=0. Input history regs d1_q=d2_q=0.
//   PFD, all outputs registered:
//     - r1 = d1 & ~d1_q and r2 = d2 & ~d2_q mark rising edges; d1_q/d2_q are the previous-cycle samples.
//     - Next state: up_n = up | r1; dn_n = dn | r2.
//     - If up_n & dn_n, both up and dn clear to 0 (reset state); otherwise they take up_n and dn_n.
//     - up and dn are therefore never 1 together.
//     - Latency is one edge: a rise sampled at edge k drives the flag after edge k.
//     - Simultaneous r1 & r2 with both flags at 0 leaves both at 0.
//     - Level-held inputs do not retrigger.
//   Loop filter, evaluated each edge using the registered up and dn:
//     - up=1: speed_var += KI, saturating at 2^SPEED_W-1.
//     - dn=1: speed_var -= KI, saturating at 0.
//     - Neither active: speed_var holds.
//     - speed_var changes one edge after the up/dn change.
//     - Arithmetic uses SPEED_W+1 bits internally, then clamps. There is no wrap-around.
//   DCO:
//     - inc = BASE_INC + zero-extended speed_var (ACC_W bits).
//     - mod=1: inc = inc >> 1.
//     - acc <= acc + inc each edge, modulo 2^ACC_W (natural wrap).
//     - signal_out is registered: acc[ACC_W-1] from the previous edge.
//     - Output frequency = f_clk * inc / 2^ACC_W.
//     - A mod change takes effect on the next accumulation; there is no phase reset.
//   A mid-operation reset restores all reset values on the edge where rst=1, with no partial state kept.
// CONFIGURATION
//   PLL_LOCK_DETECT_EN defined:
//     - Adds output lock and a counter of consecutive cycles with up=0 and dn=0.
//     - lock=1 once the count reaches LOCK_CYCLES; the counter saturates.
//     - Any cycle with up or dn set clears the counter and lock on the next edge.
//   PLL_LOCK_DETECT_EN undefined: no lock port and no counter logic.
// TESTING
//   1. Reset check: rst=1 for 2 cycles, then release.
//      -> up=dn=0, speed_var=128, signal_out=0.
//   2. Reference leads: d1 rises and is held, d2 stays 0.
//      -> up=1 after the sampling edge; speed_var 129, 130, ... one per cycle.
//      Then d2 rises -> up and dn clear; speed_var freezes.
//   3. Feedback leads, 10 d2 pulses (2 cycles high, 2 low) after reset.
//      -> dn=1 from the first pulse; speed_var decrements each cycle, clamps at 0, never wraps to 255.
//   4. d1 and d2 rise on the same edge -> up=dn=0 throughout; speed_var unchanged at 128.
//   5. DCO rate with speed_var=0 (via saturation):
//      - mod=0: inc=256, signal_out period 256 clk.
//      - mod=1: period 512 clk.
//      - speed_var=255: inc=511, period ~128.25 clk averaged over 2^ACC_W cycles.
//   6. Lock detect (PLL_LOCK_DETECT_EN):
//      - 16 quiet cycles -> lock=1.
//      - A single d1 pulse -> lock=0 the cycle after up rises.

Source files
------------

// File: rtl/dpll_if.sv
// dpll_if: PFD inputs, DCO mode and loop status bundle (lock present with PLL_LOCK_DETECT_EN)
interface dpll_if #(parameter int SPEED_W = 8);
  logic d1;
  logic d2;
  logic mod;
  logic up;
  logic dn;
  logic [SPEED_W-1:0] speed_var;
  logic signal_out;
`ifdef PLL_LOCK_DETECT_EN
  logic lock;
  modport master(output d1, d2, mod, input up, dn, speed_var, signal_out, lock);
  modport slave(input d1, d2, mod, output up, dn, speed_var, signal_out, lock);
`else
  modport master(output d1, d2, mod, input up, dn, speed_var, signal_out);
  modport slave(input d1, d2, mod, output up, dn, speed_var, signal_out);
`endif
endinterface

// File: rtl/dpll_core.sv
// dpll_core: PFD + saturating integrator + phase-accumulator DCO; lock detect under PLL_LOCK_DETECT_EN
module dpll_core #(
  parameter int SPEED_W     = 8,
  parameter int SPEED_RST   = 128,
  parameter int KI          = 1,
  parameter int ACC_W       = 16,
  parameter int BASE_INC    = 256,
  parameter int LOCK_CYCLES = 16
) (
  input logic   clk,
  input logic   rst,
  dpll_if.slave bus
);
  localparam logic [SPEED_W:0] SPEED_MAX = {1'b0, {SPEED_W{1'b1}}};
  localparam logic [SPEED_W:0] KI_W = (SPEED_W + 1)'(KI);
  logic d1_q, d2_q, up_q, dn_q, up_n, dn_n, sig_q;
  logic [SPEED_W-1:0] speed_q, speed_n;
  logic [SPEED_W:0] sum, diff;
  logic [ACC_W-1:0] acc_q, inc_full, inc;
  // edge detect, filter step with clamping, DCO increment selection
  always_comb begin
    up_n = up_q | (bus.d1 & ~d1_q);
    dn_n = dn_q | (bus.d2 & ~d2_q);
    sum = {1'b0, speed_q} + KI_W;
    diff = {1'b0, speed_q} - KI_W;
    speed_n = up_q ? (sum > SPEED_MAX ? SPEED_MAX[SPEED_W-1:0] : sum[SPEED_W-1:0]) :
              dn_q ? (diff[SPEED_W] ? '0 : diff[SPEED_W-1:0]) : speed_q;
    inc_full = ACC_W'(BASE_INC) + ACC_W'(speed_q);
    inc = bus.mod ? inc_full >> 1 : inc_full;
  end
  // PFD flags clear together when both edges have been seen; accumulator wraps naturally
  always_ff @(posedge clk) begin
    if (rst) begin
      d1_q <= 1'b0;
      d2_q <= 1'b0;
      up_q <= 1'b0;
      dn_q <= 1'b0;
      speed_q <= SPEED_W'(SPEED_RST);
      acc_q <= '0;
      sig_q <= 1'b0;
    end else begin
      d1_q <= bus.d1;
      d2_q <= bus.d2;
      up_q <= up_n & ~dn_n;
      dn_q <= dn_n & ~up_n;
      speed_q <= speed_n;
      acc_q <= acc_q + inc;
      sig_q <= acc_q[ACC_W-1];
    end
  end
  assign bus.up = up_q;
  assign bus.dn = dn_q;
  assign bus.speed_var = speed_q;
  assign bus.signal_out = sig_q;
`ifdef PLL_LOCK_DETECT_EN
  localparam int CW = $clog2(LOCK_CYCLES + 1);
  logic [CW-1:0] cnt_q;
  // count consecutive quiet cycles, saturating at the lock threshold
  always_ff @(posedge clk) begin
    if (rst || up_q || dn_q) cnt_q <= '0;
    else if (cnt_q != CW'(LOCK_CYCLES)) cnt_q <= cnt_q + CW'(1);
  end
  assign bus.lock = cnt_q == CW'(LOCK_CYCLES);
`endif
endmodule

// File: tb/tb_dpll_core.sv
// tb_dpll_core: directed self-checking bench for dpll_core
module tb_dpll_core;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_cmp = 0;
  int n_bad = 0;
  dpll_if #(.SPEED_W(8)) bus ();
  dpll_core u_dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.d1 = 1'b0;
    bus.d2 = 1'b0;
    bus.mod = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_rise(output int n);
    logic prev;
    n = 0;
    do begin
      prev = bus.signal_out;
      tick();
      n++;
    end while (!(bus.signal_out && !prev) && n < 3000);
    if (!(bus.signal_out && !prev)) n = -1;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (bus.up !== 1'b0) begin n_bad++; $display("FAIL reset_up got=%b exp=0", bus.up); end
    n_cmp++; if (bus.dn !== 1'b0) begin n_bad++; $display("FAIL reset_dn got=%b exp=0", bus.dn); end
    n_cmp++; if (bus.speed_var !== 8'd128) begin n_bad++; $display("FAIL reset_speed got=%0d exp=128", bus.speed_var); end
    n_cmp++; if (bus.signal_out !== 1'b0) begin n_bad++; $display("FAIL reset_sig got=%b exp=0", bus.signal_out); end
  endtask

  task automatic test_ref_leads();
    do_reset();
    bus.d1 = 1'b1;
    tick();
    n_cmp++; if (bus.up !== 1'b1 || bus.dn !== 1'b0) begin n_bad++; $display("FAIL lead_up got=%b%b exp=10", bus.up, bus.dn); end
    n_cmp++; if (bus.speed_var !== 8'd128) begin n_bad++; $display("FAIL lead_s0 got=%0d exp=128", bus.speed_var); end
    tick();
    n_cmp++; if (bus.speed_var !== 8'd129) begin n_bad++; $display("FAIL lead_s1 got=%0d exp=129", bus.speed_var); end
    tick();
    n_cmp++; if (bus.speed_var !== 8'd130 || bus.up !== 1'b1) begin n_bad++; $display("FAIL lead_s2 got=%0d up=%b exp=130 up=1", bus.speed_var, bus.up); end
    bus.d2 = 1'b1;
    tick();
    n_cmp++; if (bus.up !== 1'b0 || bus.dn !== 1'b0) begin n_bad++; $display("FAIL lead_clear got=%b%b exp=00", bus.up, bus.dn); end
    n_cmp++; if (bus.speed_var !== 8'd131) begin n_bad++; $display("FAIL lead_s3 got=%0d exp=131", bus.speed_var); end
    repeat (3) tick();
    n_cmp++; if (bus.speed_var !== 8'd131 || bus.up !== 1'b0 || bus.dn !== 1'b0) begin n_bad++; $display("FAIL lead_freeze got=%0d %b%b exp=131 00", bus.speed_var, bus.up, bus.dn); end
    bus.d1 = 1'b0;
    bus.d2 = 1'b0;
  endtask

  task automatic test_fb_leads();
    int exp_s;
    do_reset();
    bus.d2 = 1'b1;
    tick();
    exp_s = 128;
    n_cmp++; if (bus.dn !== 1'b1 || bus.up !== 1'b0 || bus.speed_var !== 8'(exp_s)) begin n_bad++; $display("FAIL fb_first got=%b%b %0d exp=01 128", bus.up, bus.dn, bus.speed_var); end
    for (int t = 1; t < 200; t++) begin
      bus.d2 = (t < 40) && (t % 4 < 2);
      tick();
      exp_s = (exp_s == 0) ? 0 : exp_s - 1;
      n_cmp++; if (bus.speed_var !== 8'(exp_s) || bus.dn !== 1'b1) begin n_bad++; $display("FAIL fb_t%0d got=%0d dn=%b exp=%0d dn=1", t, bus.speed_var, bus.dn, exp_s); end
    end
    n_cmp++; if (bus.speed_var !== 8'd0) begin n_bad++; $display("FAIL fb_floor got=%0d exp=0", bus.speed_var); end
    bus.d2 = 1'b0;
  endtask

  task automatic test_simultaneous();
    do_reset();
    bus.d1 = 1'b1;
    bus.d2 = 1'b1;
    for (int t = 0; t < 5; t++) begin
      tick();
      n_cmp++; if (bus.up !== 1'b0 || bus.dn !== 1'b0 || bus.speed_var !== 8'd128) begin n_bad++; $display("FAIL simul_t%0d got=%b%b %0d exp=00 128", t, bus.up, bus.dn, bus.speed_var); end
    end
    bus.d1 = 1'b0;
    bus.d2 = 1'b0;
  endtask

  task automatic test_dco();
    int p, x;
    do_reset();
    bus.d2 = 1'b1;
    tick();
    bus.d2 = 1'b0;
    repeat (135) tick();
    n_cmp++; if (bus.speed_var !== 8'd0) begin n_bad++; $display("FAIL dco_smin got=%0d exp=0", bus.speed_var); end
    wait_rise(x);
    wait_rise(p);
    n_cmp++; if (p !== 256) begin n_bad++; $display("FAIL dco_p256 got=%0d exp=256", p); end
    bus.mod = 1'b1;
    wait_rise(x);
    wait_rise(p);
    n_cmp++; if (p !== 512) begin n_bad++; $display("FAIL dco_p512 got=%0d exp=512", p); end
    do_reset();
    bus.d1 = 1'b1;
    tick();
    bus.d1 = 1'b0;
    repeat (135) tick();
    n_cmp++; if (bus.speed_var !== 8'd255) begin n_bad++; $display("FAIL dco_smax got=%0d exp=255", bus.speed_var); end
    wait_rise(x);
    for (int i = 0; i < 4; i++) begin
      wait_rise(p);
      n_cmp++; if (p != 128 && p != 129) begin n_bad++; $display("FAIL dco_pmax%0d got=%0d exp=128..129", i, p); end
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    bus.d1 = 1'b1;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    n_cmp++; if (bus.up !== 1'b0 || bus.dn !== 1'b0 || bus.speed_var !== 8'd128 || bus.signal_out !== 1'b0) begin n_bad++; $display("FAIL midrst got=%b%b %0d %b exp=00 128 0", bus.up, bus.dn, bus.speed_var, bus.signal_out); end
    rst = 1'b0;
    tick();
    n_cmp++; if (bus.up !== 1'b1 || bus.speed_var !== 8'd128) begin n_bad++; $display("FAIL midrst_hist got=%b %0d exp=1 128", bus.up, bus.speed_var); end
    bus.d1 = 1'b0;
  endtask

`ifdef PLL_LOCK_DETECT_EN
  task automatic test_lock();
    do_reset();
    n_cmp++; if (bus.lock !== 1'b0) begin n_bad++; $display("FAIL lock_rst got=%b exp=0", bus.lock); end
    repeat (15) tick();
    n_cmp++; if (bus.lock !== 1'b0) begin n_bad++; $display("FAIL lock_15 got=%b exp=0", bus.lock); end
    tick();
    n_cmp++; if (bus.lock !== 1'b1) begin n_bad++; $display("FAIL lock_16 got=%b exp=1", bus.lock); end
    bus.d1 = 1'b1;
    tick();
    bus.d1 = 1'b0;
    n_cmp++; if (bus.up !== 1'b1 || bus.lock !== 1'b1) begin n_bad++; $display("FAIL lock_up got=%b %b exp=1 1", bus.up, bus.lock); end
    tick();
    n_cmp++; if (bus.lock !== 1'b0) begin n_bad++; $display("FAIL lock_drop got=%b exp=0", bus.lock); end
  endtask
`endif

  initial begin
    bus.d1 = 1'b0;
    bus.d2 = 1'b0;
    bus.mod = 1'b0;
    test_reset();
    test_ref_leads();
    test_fb_leads();
    test_simultaneous();
    test_dco();
    test_mid_reset();
`ifdef PLL_LOCK_DETECT_EN
    test_lock();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
